onehot_mask_builder: RTL and testbench

- Write side of the request-vector path. It accumulates encoded indices into a WIDTH-bit mask through set, clear, commit and flush commands.
- On commit it publishes the mask, with its population count, over a valid/ready handshake.
- The published mask is the vector that the downstream priority decoder scans for the highest-order '1'.

---
 rtl/onehot_mask_builder_if.sv | 30 +++
 rtl/onehot_mask_builder.sv | 110 +++++++++++
 tb/tb_onehot_mask_builder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_mask_builder_if.sv
// Command/publish bundle for onehot_mask_builder: the command stream goes in,
// the committed mask with its popcount comes out.
interface onehot_mask_builder_if #(
   parameter int WIDTH = 4
);
   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 1);

   // Both channels use valid/ready: a transfer happens on a rising clk edge
   // where valid && ready; the producer holds its payload stable until then.
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_op;
   logic [IW-1:0]   in_idx;
   logic            out_valid;
   logic            out_ready;
   logic [WIDTH-1:0] out_mask;
   logic [CW-1:0]   out_count;
   logic            err;

   modport master (
      output in_valid, in_op, in_idx, out_ready,
      input  in_ready, out_valid, out_mask, out_count, err
   );

   modport slave (
      input  in_valid, in_op, in_idx, out_ready,
      output in_ready, out_valid, out_mask, out_count, err
   );
endinterface

// File: rtl/onehot_mask_builder.sv
// Accumulates SET/CLEAR/FLUSH commands into a working mask and publishes it,
// with its population count, on COMMIT for the downstream priority decoder.
module onehot_mask_builder #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   onehot_mask_builder_if.slave  bus,
   output logic [0:0]            dbg_state
);
   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [0:0] ST_BUILD = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   localparam logic [1:0] OP_SET    = 2'b00;
   localparam logic [1:0] OP_CLEAR  = 2'b01;
   localparam logic [1:0] OP_COMMIT = 2'b10;
   localparam logic [1:0] OP_FLUSH  = 2'b11;

   localparam logic [IW:0] IDX_LIM = (IW + 1)'(WIDTH);

   logic [0:0]       state;
   logic [WIDTH-1:0] wmask;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_mask_q;
   logic [CW-1:0]    out_count_q;
   logic             err_q;

   logic             accept;
   logic             idx_ok;
   logic [WIDTH-1:0] sel;

   function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // in_ready is a pure function of state, so out_ready never reaches it.
   assign bus.in_ready  = (state == ST_BUILD);
   assign bus.out_valid = out_valid_q;
   assign bus.out_mask  = out_mask_q;
   assign bus.out_count = out_count_q;
   assign bus.err       = err_q;
   assign dbg_state     = state;

   always_comb begin
      accept = bus.in_valid && (state == ST_BUILD);
      // Indices past WIDTH-1 only exist when WIDTH is not a power of two.
      idx_ok = {1'b0, bus.in_idx} < IDX_LIM;
      sel    = {{(WIDTH-1){1'b0}}, 1'b1} << bus.in_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_BUILD;
         wmask       <= '0;
         out_valid_q <= 1'b0;
         out_mask_q  <= '0;
         out_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_BUILD: begin
               if (accept) begin
                  case (bus.in_op)
                     OP_SET: begin
                        if (idx_ok) wmask <= wmask | sel;
                        else        err_q <= 1'b1;
                     end
                     OP_CLEAR: begin
                        if (idx_ok) wmask <= wmask & ~sel;
                        else        err_q <= 1'b1;
                     end
                     OP_COMMIT: begin
                        out_mask_q  <= wmask;
                        out_count_q <= popcount(wmask);
                        out_valid_q <= 1'b1;
                        wmask       <= '0;
                        state       <= ST_HOLD;
                     end
                     OP_FLUSH: begin
                        wmask <= '0;
                     end
                     default: begin
                        wmask <= wmask;
                     end
                  endcase
               end
            end
            ST_HOLD: begin
               // out_mask/out_count stay put after the handshake; consumers qualify with out_valid.
               if (out_valid_q && bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= ST_BUILD;
               end
            end
            default: begin
               state <= ST_BUILD;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_onehot_mask_builder.sv
// Directed bench for onehot_mask_builder: WIDTH=4 and WIDTH=5 instances driven
// from a vector table, plus stall and asynchronous-reset sequences.
module tb_onehot_mask_builder;
   localparam logic [1:0] OP_SET    = 2'b00;
   localparam logic [1:0] OP_CLR    = 2'b01;
   localparam logic [1:0] OP_COMMIT = 2'b10;
   localparam logic [1:0] OP_FLUSH  = 2'b11;

   typedef struct {
      bit         w5;
      logic       v;
      logic [1:0] op;
      logic [2:0] idx;
      logic       ordy;
      logic       e_rdy;
      logic       e_ov;
      logic [4:0] e_mask;
      logic [2:0] e_cnt;
      logic       e_err;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [0:0] dbg4;
   logic [0:0] dbg5;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] exp_q[$];
   logic [3:0] sb_exp;
   vec_t       tbl[$];

   onehot_mask_builder_if #(.WIDTH(4)) bus4();
   onehot_mask_builder_if #(.WIDTH(5)) bus5();

   onehot_mask_builder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4), .dbg_state(dbg4)
   );
   onehot_mask_builder #(.WIDTH(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .bus(bus5), .dbg_state(dbg5)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drivers: inputs change 1 time unit after the edge, outputs checked there too
   task automatic drive(input bit w5, input logic v, input logic [1:0] op,
                        input logic [2:0] idx, input logic ordy);
      if (w5) begin
         bus5.in_valid  = v;
         bus5.in_op     = op;
         bus5.in_idx    = idx;
         bus5.out_ready = ordy;
      end else begin
         bus4.in_valid  = v;
         bus4.in_op     = op;
         bus4.in_idx    = idx[1:0];
         bus4.out_ready = ordy;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input bit w5, input string tag, input logic e_rdy,
                            input logic e_ov, input logic [4:0] e_mask,
                            input logic [2:0] e_cnt, input logic e_err);
      if (w5) begin
         check({tag, " in_ready"},  32'(bus5.in_ready),  32'(e_rdy));
         check({tag, " out_valid"}, 32'(bus5.out_valid), 32'(e_ov));
         check({tag, " out_mask"},  32'(bus5.out_mask),  32'(e_mask));
         check({tag, " out_count"}, 32'(bus5.out_count), 32'(e_cnt));
         check({tag, " err"},       32'(bus5.err),       32'(e_err));
      end else begin
         check({tag, " in_ready"},  32'(bus4.in_ready),  32'(e_rdy));
         check({tag, " out_valid"}, 32'(bus4.out_valid), 32'(e_ov));
         check({tag, " out_mask"},  32'(bus4.out_mask),  32'(e_mask));
         check({tag, " out_count"}, 32'(bus4.out_count), 32'(e_cnt));
         check({tag, " err"},       32'(bus4.err),       32'(e_err));
      end
   endtask

   function automatic vec_t mk(input bit w5, input logic v, input logic [1:0] op,
                               input logic [2:0] idx, input logic ordy, input logic e_rdy,
                               input logic e_ov, input logic [4:0] e_mask,
                               input logic [2:0] e_cnt, input logic e_err);
      vec_t r;
      r.w5 = w5; r.v = v; r.op = op; r.idx = idx; r.ordy = ordy;
      r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_mask = e_mask; r.e_cnt = e_cnt; r.e_err = e_err;
      return r;
   endfunction

   // scoreboard: every completed WIDTH=4 publish must match the next expected mask
   always @(negedge clk) begin
      if (rst_n && bus4.out_valid && bus4.out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_publish", 32'(bus4.out_mask), 32'hFFFF_FFFF);
         end else begin
            sb_exp = exp_q.pop_front();
            check("sb_mask", 32'(bus4.out_mask), 32'(sb_exp));
         end
      end
   end

   initial begin
      //       w5 v  op         idx ordy rdy ov mask      cnt err
      // WIDTH=4: build 1100
      tbl.push_back(mk(0, 1, OP_SET,    0, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_SET,    3, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_CLR,    0, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_SET,    2, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_COMMIT, 0, 1, 0, 1, 5'b01100, 2, 0));
      tbl.push_back(mk(0, 0, OP_SET,    0, 1, 1, 0, 5'b01100, 2, 0));
      // all ones, then a HOLD-cycle SET that must be refused, then an empty commit
      tbl.push_back(mk(0, 1, OP_SET,    0, 1, 1, 0, 5'b01100, 2, 0));
      tbl.push_back(mk(0, 1, OP_SET,    1, 1, 1, 0, 5'b01100, 2, 0));
      tbl.push_back(mk(0, 1, OP_SET,    2, 1, 1, 0, 5'b01100, 2, 0));
      tbl.push_back(mk(0, 1, OP_SET,    3, 1, 1, 0, 5'b01100, 2, 0));
      tbl.push_back(mk(0, 1, OP_COMMIT, 0, 1, 0, 1, 5'b01111, 4, 0));
      tbl.push_back(mk(0, 1, OP_SET,    0, 1, 1, 0, 5'b01111, 4, 0));
      tbl.push_back(mk(0, 1, OP_COMMIT, 0, 1, 0, 1, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 0, OP_SET,    0, 1, 1, 0, 5'b00000, 0, 0));
      // redundant SET/CLEAR and FLUSH
      tbl.push_back(mk(0, 1, OP_SET,    2, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_SET,    2, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_CLR,    3, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_SET,    1, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_FLUSH,  0, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_SET,    2, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(0, 1, OP_COMMIT, 0, 1, 0, 1, 5'b00100, 1, 0));
      tbl.push_back(mk(0, 0, OP_SET,    0, 1, 1, 0, 5'b00100, 1, 0));
      // WIDTH=5: out-of-range indices raise err and leave the mask alone
      tbl.push_back(mk(1, 1, OP_SET,    2, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(1, 1, OP_SET,    6, 1, 1, 0, 5'b00000, 0, 1));
      tbl.push_back(mk(1, 1, OP_CLR,    7, 1, 1, 0, 5'b00000, 0, 1));
      tbl.push_back(mk(1, 0, OP_SET,    0, 1, 1, 0, 5'b00000, 0, 0));
      tbl.push_back(mk(1, 1, OP_COMMIT, 0, 1, 0, 1, 5'b00100, 1, 0));
      tbl.push_back(mk(1, 0, OP_SET,    0, 1, 1, 0, 5'b00100, 1, 0));
      tbl.push_back(mk(1, 1, OP_SET,    4, 1, 1, 0, 5'b00100, 1, 0));
      tbl.push_back(mk(1, 1, OP_FLUSH,  0, 1, 1, 0, 5'b00100, 1, 0));
      tbl.push_back(mk(1, 1, OP_SET,    1, 1, 1, 0, 5'b00100, 1, 0));
      tbl.push_back(mk(1, 1, OP_COMMIT, 0, 1, 0, 1, 5'b00010, 1, 0));
      tbl.push_back(mk(1, 0, OP_SET,    0, 1, 1, 0, 5'b00010, 1, 0));
      // WIDTH=5 all ones: count 5 fits in 3 bits
      for (int b = 0; b < 5; b++)
         tbl.push_back(mk(1, 1, OP_SET, 3'(b), 1, 1, 0, 5'b00010, 1, 0));
      tbl.push_back(mk(1, 1, OP_COMMIT, 0, 1, 0, 1, 5'b11111, 5, 0));
      tbl.push_back(mk(1, 0, OP_SET,    0, 1, 1, 0, 5'b11111, 5, 0));

      bus4.in_valid = 0; bus4.in_op = 0; bus4.in_idx = 0; bus4.out_ready = 1;
      bus5.in_valid = 0; bus5.in_op = 0; bus5.in_idx = 0; bus5.out_ready = 1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_out(0, "reset_w4", 1, 0, 5'b00000, 0, 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_out(0, "idle_w4", 1, 0, 5'b00000, 0, 0);
      check_out(1, "idle_w5", 1, 0, 5'b00000, 0, 0);
      check("idle_state_w4", 32'(dbg4), 32'(1'b0));

      for (int i = 0; i < tbl.size(); i++) begin
         if (!tbl[i].w5 && tbl[i].v && tbl[i].op == OP_COMMIT)
            exp_q.push_back(tbl[i].e_mask[3:0]);
         drive(tbl[i].w5, tbl[i].v, tbl[i].op, tbl[i].idx, tbl[i].ordy);
         check_out(tbl[i].w5, $sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_ov,
                   tbl[i].e_mask, tbl[i].e_cnt, tbl[i].e_err);
      end

      // stall: consumer holds off 5 cycles while a SET is offered and must be refused
      drive(0, 1, OP_SET, 3, 0);
      check_out(0, "stall_set3", 1, 0, 5'b00100, 1, 0);
      exp_q.push_back(4'b1000);
      drive(0, 1, OP_COMMIT, 0, 0);
      check_out(0, "stall_commit", 0, 1, 5'b01000, 1, 0);
      for (int c = 0; c < 5; c++) begin
         drive(0, 1, OP_SET, 1, 0);
         check_out(0, $sformatf("stall_hold%0d", c), 0, 1, 5'b01000, 1, 0);
      end
      drive(0, 1, OP_SET, 1, 1);
      check_out(0, "stall_release", 1, 0, 5'b01000, 1, 0);
      drive(0, 1, OP_SET, 1, 1);
      check_out(0, "stall_set1", 1, 0, 5'b01000, 1, 0);
      exp_q.push_back(4'b0010);
      drive(0, 1, OP_COMMIT, 0, 1);
      check_out(0, "stall_commit2", 0, 1, 5'b00010, 1, 0);
      drive(0, 0, OP_SET, 0, 1);
      check_out(0, "stall_done", 1, 0, 5'b00010, 1, 0);

      // asynchronous reset while a published mask is pending
      drive(0, 1, OP_SET, 0, 0);
      drive(0, 1, OP_COMMIT, 0, 0);
      check_out(0, "pre_reset_hold", 0, 1, 5'b00001, 1, 0);
      drive(0, 0, OP_SET, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check_out(0, "async_reset", 1, 0, 5'b00000, 0, 0);
      check("async_reset_state", 32'(dbg4), 32'(1'b0));
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_out(0, "post_reset", 1, 0, 5'b00000, 0, 0);
      check("post_reset_state", 32'(dbg4), 32'(1'b0));
      exp_q.push_back(4'b0100);
      drive(0, 1, OP_SET, 2, 1);
      drive(0, 1, OP_COMMIT, 0, 1);
      check_out(0, "post_reset_commit", 0, 1, 5'b00100, 1, 0);
      drive(0, 0, OP_SET, 0, 1);
      check_out(0, "post_reset_done", 1, 0, 5'b00100, 1, 0);
      check("sb_leftover", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
